// File: rtl/systolic_skew_fifo.sv
// systolic_skew_fifo: parametrised word FIFO feeding the MMU, with an optional
// diagonal skew output stage (lane i delayed i extra cycles).

// One output lane: a STAGES-deep shift pipe followed by the output register.
// In aligned mode the pipe is bypassed and the output register loads directly.
module skew_lane #(
   parameter int DATA_W = 8,
   parameter int STAGES = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              mode,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);
   logic [STAGES:0]             vld_pipe;
   logic [STAGES:0][DATA_W-1:0] dat_pipe;
   logic [STAGES+1:0]             vchain;
   logic [STAGES+1:0][DATA_W-1:0] dchain;
   logic [DATA_W-1:0]             in_gated;

   // bubbles carry zero data so the output is clean whenever valid is low
   assign in_gated = in_vld ? in_data : '0;
   // chain[0] is the lane input, chain[k+1] is register k; the top is the output
   assign vchain   = {vld_pipe, in_vld};
   assign dchain   = {dat_pipe, in_gated};
   assign out_vld  = vchain[STAGES+1];
   assign out_data = dchain[STAGES+1];
   assign busy     = |vchain[STAGES+1:1];

   // shift pipe; last register takes the input directly when not skewing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else if (clear) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         for (int k = 0; k <= STAGES; k++) begin
            if (k == STAGES) begin
               vld_pipe[k] <= mode ? vchain[k] : in_vld;
               dat_pipe[k] <= mode ? dchain[k] : in_gated;
            end else begin
               vld_pipe[k] <= mode & vchain[k];
               dat_pipe[k] <= mode ? dchain[k] : '0;
            end
         end
      end
   end
endmodule

module systolic_skew_fifo #(
   parameter int LANES  = 16,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    skew_mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    pop,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES-1:0]        out_valid,
   output logic [CNT_W-1:0]        count,
   output logic                    full,
   output logic                    empty,
   output logic                    skew_busy,
   output logic                    overflow,
   output logic                    underflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int W     = LANES * DATA_W;

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [CNT_W-1:0]        cnt_nxt;
   logic                    push_ok, pop_ok, mode_q;
   logic [W-1:0]            iss_data;
   logic [LANES-1:0]        lane_busy;

   assign in_ready  = !full;
   assign push_ok   = in_valid && !full && !clear;
   assign pop_ok    = pop && !empty && !clear;
   assign iss_data  = pop_ok ? mem[rd_ptr] : '0;
   assign skew_busy = |lane_busy;

   // next occupancy; clear wins over everything
   always_comb begin
      cnt_nxt = count;
      if (clear)                 cnt_nxt = '0;
      else if (push_ok && !pop_ok) cnt_nxt = count + 1'b1;
      else if (pop_ok && !push_ok) cnt_nxt = count - 1'b1;
   end

   // storage write; data needs no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= in_data;
   end

   // pointers, occupancy and registered full/empty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         end
         count <= cnt_nxt;
         full  <= (cnt_nxt == CNT_W'(DEPTH));
         empty <= (cnt_nxt == '0);
      end
   end

   // sticky error flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (in_valid && full) overflow  <= 1'b1;
         if (pop && empty)     underflow <= 1'b1;
      end
   end

   // mode only changes while the output stage is idle, so no word straddles modes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           mode_q <= 1'b0;
      else if (!clear && !skew_busy && !pop_ok) mode_q <= skew_mode;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      skew_lane #(.DATA_W(DATA_W), .STAGES(i)) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .clear    (clear),
         .mode     (mode_q),
         .in_vld   (pop_ok),
         .in_data  (iss_data[i*DATA_W +: DATA_W]),
         .out_vld  (out_valid[i]),
         .out_data (out_data[i*DATA_W +: DATA_W]),
         .busy     (lane_busy[i])
      );
   end
endmodule

// File: doc/systolic_skew_fifo.md
Name: systolic_skew_fifo

Overview:
- Parametrised successor to the fixed 16-lane, depth-4 data/weight FIFOs that feed the matrix-multiply unit.
- Adds configurable lane count, element width and depth, plus a valid/ready push side, occupancy and error flags, and a synchronous flush.
- Adds an optional diagonal skew stage on the output side: lane i is delayed i extra cycles, so the MMU receives a systolic wavefront directly.
- Sits between the unified/weight buffer read port and the MMU ain/win inputs.

Parameters:
- LANES, 16, number of parallel elements per word (>=1).
- DATA_W, 8, bits per element.
- DEPTH, 4, FIFO word capacity; must be a power of 2 and >=2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of FIFO, skew pipes and error flags.
- skew_mode  in  1  0 = aligned output, 1 = diagonal skew; sampled only while idle.
- in_valid  in  1  push request.
- in_ready  out  1  FIFO can accept a word; equals !full.
- in_data  in  LANES*DATA_W  push word; lane i occupies bits [i*DATA_W +: DATA_W].
- pop  in  1  consumer request to issue one word into the output stage.
- out_data  out  LANES*DATA_W  registered, per-lane (skewed) output toward the MMU.
- out_valid  out  LANES  per-lane valid for out_data.
- count  out  CNT_W  words currently stored (0..DEPTH).
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- skew_busy  out  1  any out_valid bit or internal skew-pipe valid bit is set.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset_n=0, asynchronous) values:
  - rd/wr pointers, count, out_data, out_valid, all skew pipes, overflow, underflow = 0.
  - empty=1, full=0, in_ready=1, latched mode=0.
- Storage: circular buffer of DEPTH words; pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push accepted iff in_valid && !full. The word is written at wr_ptr and wr_ptr increments.
- Pop accepted iff pop && !empty. The word at rd_ptr is issued to the output stage and rd_ptr increments.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- When full, in_ready=0, so a push in the same cycle as a pop at full is not accepted.
- Error flags:
  - Push while full: no state change; overflow set to 1 and held until clear or reset.
  - Pop while empty: no state change; underflow set to 1 and held.
- Output stage, aligned (latched mode=0):
  - The cycle after an accepted pop, out_data holds the word and out_valid = all ones.
  - Otherwise out_valid = 0 and out_data = 0. Latency is 1 cycle for every lane.
- Output stage, skew (latched mode=1):
  - Lane i of a word popped at cycle t appears on out_data lane i with out_valid[i]=1 at cycle t+1+i.
  - Each lane has an i-stage shift pipe that advances every cycle, whether or not a pop occurs.
  - Bubbles shift through with valid=0 and data=0. Back-to-back pops produce a continuous diagonal wavefront.
  - Full drain after the last pop takes LANES cycles.
- Mode latch: skew_mode is captured into the latched mode on any cycle with skew_busy=0 and no accepted pop. Changes while busy are ignored until the pipes drain.
- clear has priority over push and pop in the same cycle. It zeros pointers, count, skew pipes, out_valid, out_data and both error flags. It does not change the latched mode.
- Reset asserted mid-operation discards all stored and in-flight data immediately.
- count, full and empty are registered and reflect accepted operations from the previous edge.

Test Plan:
- Reset: hold reset_n=0, then release -> count=0, empty=1, full=0, in_ready=1, out_valid=0, overflow=0, underflow=0.
- Fill/overflow (DEPTH=4): push words 0x01..0x04 -> full=1, in_ready=0, count=4. A 5th push -> count stays 4, overflow=1. Pop 4 -> aligned outputs 0x01..0x04 in order, one cycle after each pop.
- Underflow and wrap: pop while empty -> underflow=1, count=0. Then run 10 push/pop pairs through DEPTH=4 -> data order preserved across pointer wrap, count returns to 0.
- Simultaneous push/pop at count=2 -> count remains 2 and the popped word is the oldest one.
- Skew (LANES=4, skew_mode=1): push lane values {4,3,2,1} (lane0=1), pop at cycle t:
  - out_valid[0]=1 with value 1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4.
  - skew_busy falls at t+5.
  - Toggling skew_mode at t+2 has no effect until drained.
- Clear mid-operation: 3 words stored, skew pipe in flight, overflow=1, assert clear with push and pop also high -> next cycle count=0, empty=1, out_valid=0, overflow=0, and neither the push nor the pop takes effect.
